// File: rtl/baseline_tracker_pkg.sv
// Shared sizing helpers and window state encoding for the baseline_tracker slice.
package baseline_pkg;

  localparam int LANE_W     = 16;
  localparam int LANES      = 128 / LANE_W;
  localparam int LANES_LOG2 = $clog2(LANES);

  function automatic int f_lanes(input int tdata_w);
    return tdata_w / LANE_W;
  endfunction

  function automatic int f_log2(input int n);
    return $clog2(n);
  endfunction

  function automatic int f_sum_w(input int adc_w, input int lanes);
    return adc_w + $clog2(lanes);
  endfunction

  function automatic int f_acc_w(input int adc_w, input int lanes, input int avg_log2);
    return f_sum_w(adc_w, lanes) + avg_log2;
  endfunction

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    CLOSE = 1'b1
  } state_t;

endpackage

// File: rtl/baseline_tracker_lane_adder.sv
// Stage 1 of baseline_tracker: lane extraction, registered lane sum and beat taint.
// Outlier compare is built only when BASELINE_REJECT_EN is defined.
module lane_adder
  import baseline_pkg::*;
#(
  parameter int ADC_W         = 12,
  parameter int TDATA_W       = 128,
  parameter int REJECT_MARGIN = 64,
  localparam int LANES_L      = f_lanes(TDATA_W),
  localparam int SUM_W        = f_sum_w(ADC_W, LANES_L)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [TDATA_W-1:0]       i_tdata,
  input  logic                     i_tvalid,
  input  logic                     i_hold,
  input  logic                     i_last,
  input  logic signed [ADC_W-1:0]  i_baseline,
  output logic signed [SUM_W-1:0]  o_sum,
  output logic                     o_taint,
  output logic                     o_last,
  output logic                     o_vld
);

  logic signed [ADC_W-1:0] w_lane [LANES_L];
  logic signed [SUM_W-1:0] w_sum;
  logic                    w_outlier;
  logic                    w_unused;

  logic signed [SUM_W-1:0] r_sum_p1;
  logic                    r_taint_p1;
  logic                    r_last_p1;
  logic                    r_vld_p1;

  for (genvar j = 0; j < LANES_L; j++) begin : g_lane
    assign w_lane[j] = i_tdata[16*j+15 -: ADC_W];
  end

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < LANES_L; j++) begin
      w_sum = w_sum + SUM_W'(w_lane[j]);
    end
  end

`ifdef BASELINE_REJECT_EN
  // One extra bit keeps baseline + margin from wrapping near full scale.
  logic signed [ADC_W:0] w_limit;
  assign w_limit = (ADC_W+1)'(i_baseline) + (ADC_W+1)'(REJECT_MARGIN);

  always_comb begin
    w_outlier = 1'b0;
    for (int j = 0; j < LANES_L; j++) begin
      if ((ADC_W+1)'(w_lane[j]) > w_limit) w_outlier = 1'b1;
    end
  end

  assign w_unused = ^i_tdata;
`else
  assign w_outlier = 1'b0;
  assign w_unused  = ^{i_tdata, i_baseline};
`endif

  // ---- stage 1 boundary ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_vld_p1 <= 1'b0;
    else          r_vld_p1 <= i_tvalid;
  end

  always_ff @(posedge i_clk) begin
    if (i_tvalid) begin
      r_sum_p1   <= w_sum;
      r_taint_p1 <= i_hold | w_outlier;
      r_last_p1  <= i_last;
    end
  end

  assign o_sum   = r_sum_p1;
  assign o_taint = r_taint_p1;
  assign o_last  = r_last_p1;
  assign o_vld   = r_vld_p1;

endmodule

// File: rtl/baseline_tracker.sv
// Windowed ADC baseline estimator feeding the MM trigger BASELINE input.
// Optional outlier rejection: define BASELINE_REJECT_EN.
module baseline_tracker
  import baseline_pkg::*;
#(
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int S_AXIS_TDATA_WIDTH   = 128,
  parameter int AVG_LEN_LOG2         = 4,
  parameter int INIT_BASELINE        = -2037,
  parameter int REJECT_MARGIN        = 64
) (
  input  logic                                   AXIS_ACLK,
  input  logic                                   AXIS_ARESETN,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]          S_AXIS_TDATA,
  input  logic                                   S_AXIS_TVALID,
  input  logic                                   HOLD,
  output logic signed [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
  output logic                                   BASELINE_VALID,
  output logic                                   UPDATE,
  output logic                                   WINDOW_DISCARD
);

  localparam int ADC_W   = ADC_RESOLUTION_WIDTH;
  localparam int LANES_T = f_lanes(S_AXIS_TDATA_WIDTH);
  localparam int SUM_W   = f_sum_w(ADC_W, LANES_T);
  localparam int ACC_W   = f_acc_w(ADC_W, LANES_T, AVG_LEN_LOG2);
  localparam int SHIFT   = f_log2(LANES_T) + AVG_LEN_LOG2;
  localparam logic [AVG_LEN_LOG2-1:0] CNT_MAX = '1;

  // Arithmetic shift floors toward -inf; the mean always fits ADC_W bits.
  function automatic logic signed [ADC_W-1:0] f_window_mean(input logic signed [ACC_W-1:0] total);
    logic signed [ACC_W-1:0] shifted;
    shifted = total >>> SHIFT;
    return shifted[ADC_W-1:0];
  endfunction

  logic [AVG_LEN_LOG2-1:0]  r_cnt;
  logic                     w_last_p0;

  logic signed [SUM_W-1:0]  w_sum_p1;
  logic                     w_taint_p1;
  logic                     w_last_p1;
  logic                     w_vld_p1;

  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_dirty;
  state_t                   r_state;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic                     w_dirty_next;
  logic signed [ACC_W-1:0]  r_total_p2;
  logic                     r_dirty_p2;

  logic signed [ADC_W-1:0]  r_baseline;
  logic                     r_baseline_valid;
  logic                     r_update;
  logic                     r_discard;

  assign w_last_p0 = (r_cnt == CNT_MAX);

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN)      r_cnt <= '0;
    else if (S_AXIS_TVALID) r_cnt <= r_cnt + AVG_LEN_LOG2'(1);
  end

  lane_adder #(
    .ADC_W         (ADC_W),
    .TDATA_W       (S_AXIS_TDATA_WIDTH),
    .REJECT_MARGIN (REJECT_MARGIN)
  ) u_lane_adder (
    .i_clk      (AXIS_ACLK),
    .i_rst_n    (AXIS_ARESETN),
    .i_tdata    (S_AXIS_TDATA),
    .i_tvalid   (S_AXIS_TVALID),
    .i_hold     (HOLD),
    .i_last     (w_last_p0),
    .i_baseline (r_baseline),
    .o_sum      (w_sum_p1),
    .o_taint    (w_taint_p1),
    .o_last     (w_last_p1),
    .o_vld      (w_vld_p1)
  );

  assign w_acc_next   = r_acc + ACC_W'(w_sum_p1);
  assign w_dirty_next = r_dirty | w_taint_p1;

  // ---- stage 2 boundary: accumulate, close window into total register ----
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_acc   <= '0;
      r_dirty <= 1'b0;
      r_state <= FILL;
    end else begin
      r_state <= FILL;
      if (w_vld_p1) begin
        if (w_last_p1) begin
          r_acc   <= '0;
          r_dirty <= 1'b0;
          r_state <= CLOSE;
        end else begin
          r_acc   <= w_acc_next;
          r_dirty <= w_dirty_next;
        end
      end
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (w_vld_p1 && w_last_p1) begin
      r_total_p2 <= w_acc_next;
      r_dirty_p2 <= w_dirty_next;
    end
  end

  // ---- stage 3 boundary: output registers ----
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_baseline       <= ADC_W'(INIT_BASELINE);
      r_baseline_valid <= 1'b0;
      r_update         <= 1'b0;
      r_discard        <= 1'b0;
    end else begin
      r_update  <= (r_state == CLOSE) && !r_dirty_p2;
      r_discard <= (r_state == CLOSE) &&  r_dirty_p2;
      if ((r_state == CLOSE) && !r_dirty_p2) begin
        r_baseline       <= f_window_mean(r_total_p2);
        r_baseline_valid <= 1'b1;
      end
    end
  end

  assign BASELINE       = r_baseline;
  assign BASELINE_VALID = r_baseline_valid;
  assign UPDATE         = r_update;
  assign WINDOW_DISCARD = r_discard;

endmodule

// File: tb/tb_baseline_tracker.sv
// Directed plus randomized bench for baseline_tracker against a window-level reference model.
module tb_baseline_tracker;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [127:0]       tdata;
  logic               tvalid;
  logic               hold;
  logic signed [11:0] bl;
  logic               bl_valid;
  logic               upd;
  logic               disc;

  baseline_tracker dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESETN   (rst_n),
    .S_AXIS_TDATA   (tdata),
    .S_AXIS_TVALID  (tvalid),
    .HOLD           (hold),
    .BASELINE       (bl),
    .BASELINE_VALID (bl_valid),
    .UPDATE         (upd),
    .WINDOW_DISCARD (disc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    bit upd;
    int val;
  } ev_t;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  int     cur_lane [8];
  ev_t    pend [$];
  int     upd_cyc [$];
  int     upd_val [$];
  int     dis_cyc [$];
  int     m_cnt   = 0;
  longint m_sum   = 0;
  bit     m_dirty = 0;
  int     m_bl    = -2037;
  bit     m_valid = 0;
  int     mark;
  int     n_upd;
  int     n_dis;

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input longint num, input longint den);
    longint q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return int'(q);
  endfunction

  task automatic set_all(input int v);
    for (int j = 0; j < 8; j++) cur_lane[j] = v;
  endtask

  // One clock: drive a beat, advance the window model, check outputs after the edge.
  task automatic step(input bit v, input bit h);
    logic [127:0] td;
    logic [31:0]  lv;
    bit           t;
    bit           eu;
    bit           ed;
    longint       bsum;
    ev_t          e;
    for (int j = 0; j < 8; j++) begin
      lv = cur_lane[j];
      td[16*j +: 16] = {lv[11:0], 4'($urandom)};
    end
    tdata  = td;
    tvalid = v;
    hold   = h;
    if (v) begin
      t    = h;
      bsum = 0;
      for (int j = 0; j < 8; j++) begin
        bsum += cur_lane[j];
`ifdef BASELINE_REJECT_EN
        if (cur_lane[j] > m_bl + 64) t = 1;
`endif
      end
      m_sum   += bsum;
      m_dirty |= t;
      if (m_cnt == 15) begin
        e.due = cyc + 3;
        e.upd = !m_dirty;
        e.val = floor_div(m_sum, 128);
        pend.push_back(e);
        m_cnt   = 0;
        m_sum   = 0;
        m_dirty = 0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    eu = 0;
    ed = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      if (e.upd) begin
        eu      = 1;
        m_bl    = e.val;
        m_valid = 1;
      end else begin
        ed = 1;
      end
    end
    if (upd === 1'b1) begin
      upd_cyc.push_back(cyc);
      upd_val.push_back(int'(bl));
    end
    if (disc === 1'b1) dis_cyc.push_back(cyc);
    chk("update", {31'd0, upd}, int'(eu));
    chk("discard", {31'd0, disc}, int'(ed));
    chk("baseline", bl, m_bl);
    chk("bl_valid", {31'd0, bl_valid}, int'(m_valid));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tvalid = 1'b0;
    hold   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_baseline", bl, -2037);
    chk("rst_valid", {31'd0, bl_valid}, 0);
    chk("rst_update", {31'd0, upd}, 0);
    chk("rst_discard", {31'd0, disc}, 0);
    pend.delete();
    m_cnt   = 0;
    m_sum   = 0;
    m_dirty = 0;
    m_bl    = -2037;
    m_valid = 0;
    @(posedge clk);
    cyc++;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    tvalid = 1'b0;
    hold   = 1'b0;
    tdata  = '0;
    set_all(0);
    @(posedge clk);
    cyc++;
    #1;
    chk("init_baseline", bl, -2037);
    chk("init_valid", {31'd0, bl_valid}, 0);
    chk("init_update", {31'd0, upd}, 0);
    chk("init_discard", {31'd0, disc}, 0);
    rst_n = 1'b1;
    idle(2);

    // Partial window, then reset mid-window.
    set_all(500);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    do_reset();

    // Alternating -2038/-2036 lanes: window starts afresh at beat 0.
    for (int j = 0; j < 8; j++) cur_lane[j] = (j % 2 == 0) ? -2038 : -2036;
    upd_cyc.delete();
    upd_val.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    mark = cyc;
    idle(3);
    chk("alt_baseline", bl, -2037);
    chk("alt_valid", {31'd0, bl_valid}, 1);
    chk("alt_latency", (upd_cyc.size() > 0) ? upd_cyc[0] - mark : -1, 2);

    // Constant 100 with TVALID toggling.
    set_all(100);
    n_upd = upd_cyc.size();
    for (int i = 0; i < 32; i++) step(i % 2 == 0, 1'b0);
    idle(3);
    chk("toggle_baseline", bl, 100);
    chk("toggle_updates", upd_cyc.size() - n_upd, 1);

    // HOLD on beat 7 taints the window; next clean window updates.
    n_dis = dis_cyc.size();
    for (int i = 0; i < 16; i++) step(1'b1, i == 7);
    idle(3);
    chk("hold_discards", dis_cyc.size() - n_dis, 1);
    chk("hold_baseline", bl, 100);
    set_all(200);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    idle(3);
    chk("after_hold_baseline", bl, 200);

    // One 1228 outlier among -2037 samples.
    do_reset();
    set_all(-2037);
    n_upd = upd_cyc.size();
    n_dis = dis_cyc.size();
    for (int i = 0; i < 16; i++) begin
      cur_lane[3] = (i == 5) ? 1228 : -2037;
      step(1'b1, 1'b0);
    end
    idle(3);
`ifdef BASELINE_REJECT_EN
    chk("outlier_discard", dis_cyc.size() - n_dis, 1);
    chk("outlier_baseline", bl, -2037);
`else
    chk("outlier_update", upd_cyc.size() - n_upd, 1);
    chk("outlier_baseline", bl, -2012);
`endif

    // Full-scale extremes, then two contiguous windows of 2047.
    upd_cyc.delete();
    upd_val.delete();
    set_all(-2048);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    set_all(2047);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0);
    idle(3);
    chk("extreme_updates", upd_cyc.size(), 3);
    if (upd_cyc.size() == 3) begin
      chk("neg_fullscale", upd_val[0], -2048);
      chk("pos_gap", upd_cyc[2] - upd_cyc[1], 16);
    end
    chk("pos_fullscale", bl, 2047);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 170) do_reset();
      for (int j = 0; j < 8; j++) begin
        if ($urandom_range(9) == 0) cur_lane[j] = ($urandom_range(1) == 0) ? -2048 : 2047;
        else                        cur_lane[j] = int'($urandom_range(4095)) - 2048;
      end
      step($urandom_range(3) != 0, $urandom_range(24) == 0);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baseline_tracker.md
# baseline_tracker

Upstream companion to the MM trigger: continuously estimates the ADC baseline from the RF Data Converter stream and drives the trigger's `BASELINE` input. It averages fixed windows of valid beats, and discards any window that overlaps a trigger or that contains an outlier sample. Each accepted window produces one registered baseline update.

## Interface

- `ADC_RESOLUTION_WIDTH`, 12: sample width; each sample is MSB-aligned in a 16-bit lane.
- `S_AXIS_TDATA_WIDTH`, 128: stream width; LANES = `S_AXIS_TDATA_WIDTH`/16 (8 at default).
- `AVG_LEN_LOG2`, 4: window length = 2^`AVG_LEN_LOG2` valid beats.
- `INIT_BASELINE`, -2037: signed reset value of `BASELINE`.
- `REJECT_MARGIN`, 64: outlier margin above the current baseline; used only with `BASELINE_REJECT_EN`.
- `AXIS_ACLK`  in  1  the single clock, rising edge.
- `AXIS_ARESETN`  in  1  reset, asynchronous and active-low.
- `S_AXIS_TDATA`  in  `S_AXIS_TDATA_WIDTH`  sample lanes; sample j = `S_AXIS_TDATA`[16j+15 -: `ADC_RESOLUTION_WIDTH`], signed.
- `S_AXIS_TVALID`  in  1  beat qualifier; the block never backpressures.
- `HOLD`  in  1  expanded trigger; a beat sampled with `HOLD`=1 taints its window.
- `BASELINE`  out  `ADC_RESOLUTION_WIDTH`  signed registered baseline estimate.
- `BASELINE_VALID`  out  1  sticky; set by the first accepted window.
- `UPDATE`  out  1  one-cycle pulse on each accepted window.
- `WINDOW_DISCARD`  out  1  one-cycle pulse on each discarded window.

## Operation

- Beats are counted only when `S_AXIS_TVALID`=1. Cycles with `S_AXIS_TVALID`=0 leave the counter, accumulator and taint flag untouched.
- **Stage 1 (lane stage):**
  - Registers the signed sum of all LANES samples. Width is `ADC_RESOLUTION_WIDTH`+log2(LANES), 15 bits at default.
  - Registers a beat-taint flag = `HOLD` OR any-outlier.
  - Registers a last-beat flag, set when the beat counter equals 2^`AVG_LEN_LOG2`-1.
- **Stage 2 (accumulator):**
  - ACC width is `ADC_RESOLUTION_WIDTH`+log2(LANES)+`AVG_LEN_LOG2`, signed, 19 bits at default. It cannot overflow.
  - DIRTY = OR of the taint flags over the window.
  - On a last beat, the window closes:
    - If the window is clean, `BASELINE` <= (ACC + this beat's sum) >>> (log2(LANES)+`AVG_LEN_LOG2`). This is an arithmetic shift, so the result is the floor toward −∞. `UPDATE`=1 and `BASELINE_VALID`=1.
    - If the window is dirty (including taint on the last beat itself), `BASELINE` holds and `WINDOW_DISCARD`=1.
  - In both cases ACC and DIRTY are cleared in the same cycle.
- **Beat counter:** `AVG_LEN_LOG2` bits. It wraps from 2^`AVG_LEN_LOG2`-1 to 0 with no idle gap, so back-to-back windows are contiguous.
- **State machine:** FILL (counter < max) → CLOSE (last beat in stage 2) → FILL. CLOSE lasts exactly one cycle.
- **Simultaneous events:** `HOLD` and an outlier on the same beat count as a single taint.
- **Reset:** the asynchronous reset aborts any partial window. After reset:
  - counter = 0, ACC = 0, DIRTY = 0, pipeline valids = 0;
  - `BASELINE` = `INIT_BASELINE`, `BASELINE_VALID` = 0, `UPDATE` = 0, `WINDOW_DISCARD` = 0.

## Timing

- Final beat of a window sampled at edge N → `BASELINE`, `UPDATE` and `WINDOW_DISCARD` change at edge N+2.
- `UPDATE` and `WINDOW_DISCARD` are mutually exclusive and each is high for exactly one cycle.
- `BASELINE` is stable between updates and never changes while `UPDATE`=0.
- The outlier compare uses the registered `BASELINE` value at the time the beat is sampled. It is a signed compare at `ADC_RESOLUTION_WIDTH`+1 bits, so `BASELINE`+`REJECT_MARGIN` cannot overflow.
- Throughput is one beat per cycle, sustained indefinitely.

## Configuration

- `BASELINE_REJECT_EN` defined: a sample greater than `BASELINE`+`REJECT_MARGIN` taints its window.
- `BASELINE_REJECT_EN` undefined:
  - the outlier term is constant 0, so only `HOLD` taints;
  - `REJECT_MARGIN` is ignored and no compare logic is built.

## Structure

- Package `baseline_pkg` holds:
  - LANES and its log2;
  - lane-sum width and accumulator width functions;
  - the state enum {FILL, CLOSE}.
- One sub-module, `lane_adder`, implements stage 1: lane extraction, registered adder tree, and per-lane outlier compare under `BASELINE_REJECT_EN`.
- The top level holds the beat counter, accumulator, taint tracking and output registers.

## Test plan

All scenarios use default parameters; a window is 16 beats (128 samples).

1. Reset asserted mid-window → `BASELINE`=-2037, `BASELINE_VALID`=0, `UPDATE`=0 and `WINDOW_DISCARD`=0 immediately. The next window starts from beat 0.
2. Lanes alternating -2038/-2036 for 16 continuous beats → `UPDATE` pulse 2 cycles after beat 16, `BASELINE`=-2037, `BASELINE_VALID`=1.
3. All samples = 100 for 16 beats with `S_AXIS_TVALID` toggling every cycle (32 cycles total) → a single `UPDATE`, `BASELINE`=100.
4. `HOLD`=1 on beat 7 only, all samples 100 → `WINDOW_DISCARD` pulse, `BASELINE` unchanged, no `UPDATE`. The following clean window updates normally.
5. 127 samples of -2037 and one sample of 1228 in a window, starting from `BASELINE`=-2037:
   - with `BASELINE_REJECT_EN` → `WINDOW_DISCARD`, `BASELINE` stays -2037;
   - without it → `UPDATE`, `BASELINE`=-2012 (sum -257471 >>> 7).
6. All samples = -2048 for 16 beats → `BASELINE`=-2048 with no overflow. Then 32 contiguous beats of 2047 → two consecutive `UPDATE` pulses exactly 16 cycles apart, final `BASELINE`=2047.
